// File: rtl/meta_pkt_sf_fifo.sv
// Store-and-forward packet FIFO for the tx_meta stream.
// Beats are written into a beat RAM; a packet becomes visible to the read side only once its
// eop beat has been written (commit). Oversize packets and framing errors are discarded
// atomically by rewinding the write pointer to the last commit point.
//
// Ports:
//   clk, rst                  single clock, synchronous active-high reset
//   in_meta_*                 input beat stream (data/keep/tid/tdt/sop/eop, vld/rdy)
//   out_meta_*                output beat stream, same handshake
//   drop_cnt                  packets dropped for lack of beat storage (saturating)
//   err_cnt                   framing errors: orphan beat or missing eop (saturating)
//   pkt_level                 committed packets whose eop has not yet left the output
module meta_pkt_sf_fifo #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned KEEP_W    = 16,
  parameter int unsigned TID_W     = 4,
  parameter int unsigned TDT_W     = 4,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PKT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_W-1:0]            in_meta_data,
  input  logic [KEEP_W-1:0]            in_meta_keep,
  input  logic                         in_meta_vld,
  input  logic [TID_W-1:0]             in_meta_tid,
  input  logic [TDT_W-1:0]             in_meta_tdt,
  input  logic                         in_meta_sop,
  input  logic                         in_meta_eop,
  output logic                         in_meta_rdy,
  output logic [DATA_W-1:0]            out_meta_data,
  output logic [KEEP_W-1:0]            out_meta_keep,
  output logic                         out_meta_vld,
  output logic [TID_W-1:0]             out_meta_tid,
  output logic [TDT_W-1:0]             out_meta_tdt,
  output logic                         out_meta_sop,
  output logic                         out_meta_eop,
  input  logic                         out_meta_rdy,
  output logic [15:0]                  drop_cnt,
  output logic [15:0]                  err_cnt,
  output logic [$clog2(PKT_DEPTH):0]   pkt_level
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned LW     = $clog2(PKT_DEPTH) + 1;
  localparam int unsigned WORD_W = DATA_W + KEEP_W + TID_W + TDT_W + 2;

  typedef logic [AW:0]   ptr_t;
  typedef logic [LW-1:0] lvl_t;

  typedef enum logic [1:0] {StIdle, StPkt, StDrop} wr_state_e;

  wr_state_e state_q, state_d;

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t commit_ptr_q, commit_ptr_d;
  ptr_t rd_ptr_q;
  ptr_t base_ptr;
  lvl_t pkt_level_q;

  logic        rst_q;
  logic [15:0] drop_cnt_q, err_cnt_q;

  logic             in_acc;
  logic             space_full;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic             commit, err_inc, drop_inc;
  logic [WORD_W-1:0] in_word;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q;
  logic              ram_vld_q;
  logic [WORD_W-1:0] out_word_q;
  logic              out_vld_q;

  logic avail, load_out, rd_en, out_eop_hs;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  // Only the committed-packet count throttles input; beat overflow is handled by dropping.
  assign in_meta_rdy = !rst_q && (pkt_level_q < lvl_t'(PKT_DEPTH));
  assign in_acc      = in_meta_vld && in_meta_rdy;
  assign in_word     = {in_meta_data, in_meta_keep, in_meta_tid, in_meta_tdt,
                        in_meta_sop, in_meta_eop};

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    mem_we       = 1'b0;
    commit       = 1'b0;
    err_inc      = 1'b0;
    drop_inc     = 1'b0;
    // A sop inside a packet restarts it from the last commit point.
    base_ptr     = (state_q == StPkt && in_meta_sop) ? commit_ptr_q : wr_ptr_q;
    space_full   = ptr_t'(base_ptr - rd_ptr_q) == ptr_t'(DEPTH);
    mem_waddr    = base_ptr[AW-1:0];

    if (in_acc) begin
      unique case (state_q)
        StIdle: begin
          if (!in_meta_sop) begin
            err_inc = 1'b1;
          end else if (space_full) begin
            if (in_meta_eop) drop_inc = 1'b1;
            else             state_d  = StDrop;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = base_ptr + ptr_t'(1);
            if (in_meta_eop) begin
              commit       = 1'b1;
              commit_ptr_d = base_ptr + ptr_t'(1);
            end else begin
              state_d = StPkt;
            end
          end
        end
        StPkt: begin
          if (in_meta_sop) err_inc = 1'b1;
          if (space_full) begin
            wr_ptr_d = commit_ptr_q;
            if (in_meta_eop) begin
              drop_inc = 1'b1;
              state_d  = StIdle;
            end else begin
              state_d = StDrop;
            end
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = base_ptr + ptr_t'(1);
            if (in_meta_eop) begin
              commit       = 1'b1;
              commit_ptr_d = base_ptr + ptr_t'(1);
              state_d      = StIdle;
            end
          end
        end
        StDrop: begin
          if (in_meta_eop) begin
            wr_ptr_d = commit_ptr_q;
            drop_inc = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read side: sync-read RAM stage followed by the output register
  // ---------------------------------------------------------------------------
  assign avail      = rd_ptr_q != commit_ptr_q;
  assign load_out   = ram_vld_q && (!out_vld_q || out_meta_rdy);
  assign rd_en      = avail && (!ram_vld_q || load_out);
  assign out_eop_hs = out_vld_q && out_meta_rdy && out_word_q[0];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= in_word;
    if (rd_en)  ram_q <= mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pkt_level_q  <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
      out_word_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      pkt_level_q  <= pkt_level_q + lvl_t'(commit) - lvl_t'(out_eop_hs);
      if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      if (err_inc && err_cnt_q != 16'hFFFF)   err_cnt_q  <= err_cnt_q + 16'd1;

      if (rd_en) begin
        rd_ptr_q  <= rd_ptr_q + ptr_t'(1);
        ram_vld_q <= 1'b1;
      end else if (load_out) begin
        ram_vld_q <= 1'b0;
      end

      if (load_out) begin
        out_word_q <= ram_q;
        out_vld_q  <= 1'b1;
      end else if (out_meta_rdy) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign {out_meta_data, out_meta_keep, out_meta_tid, out_meta_tdt,
          out_meta_sop, out_meta_eop} = out_word_q;
  assign out_meta_vld = out_vld_q;
  assign drop_cnt     = drop_cnt_q;
  assign err_cnt      = err_cnt_q;
  assign pkt_level    = pkt_level_q;

endmodule

// File: tb/tb_meta_pkt_sf_fifo.sv
// Directed testbench for meta_pkt_sf_fifo.
module tb_meta_pkt_sf_fifo;

  localparam int DATA_W = 128;
  localparam int KEEP_W = 16;
  localparam int TID_W  = 4;
  localparam int TDT_W  = 4;
  localparam int DEPTH  = 64;
  localparam int PKT_DEPTH = 16;
  localparam int WORD_W = DATA_W + KEEP_W + TID_W + TDT_W + 2;

  typedef logic [WORD_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic [KEEP_W-1:0] in_keep = '0;
  logic              in_vld = 1'b0;
  logic [TID_W-1:0]  in_tid = '0;
  logic [TDT_W-1:0]  in_tdt = '0;
  logic              in_sop = 1'b0;
  logic              in_eop = 1'b0;
  logic              in_rdy;
  logic [DATA_W-1:0] out_data;
  logic [KEEP_W-1:0] out_keep;
  logic              out_vld;
  logic [TID_W-1:0]  out_tid;
  logic [TDT_W-1:0]  out_tdt;
  logic              out_sop;
  logic              out_eop;
  logic              out_rdy = 1'b0;
  logic [15:0]       drop_cnt;
  logic [15:0]       err_cnt;
  logic [4:0]        pkt_level;

  int checks = 0;
  int failures = 0;

  word_t cap[$];
  word_t exp_q[$];
  word_t prev_word;
  logic  prev_stall = 1'b0;

  always #5 clk = ~clk;

  meta_pkt_sf_fifo #(
    .DATA_W(DATA_W), .KEEP_W(KEEP_W), .TID_W(TID_W), .TDT_W(TDT_W),
    .DEPTH(DEPTH), .PKT_DEPTH(PKT_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_meta_data(in_data), .in_meta_keep(in_keep), .in_meta_vld(in_vld),
    .in_meta_tid(in_tid), .in_meta_tdt(in_tdt), .in_meta_sop(in_sop),
    .in_meta_eop(in_eop), .in_meta_rdy(in_rdy),
    .out_meta_data(out_data), .out_meta_keep(out_keep), .out_meta_vld(out_vld),
    .out_meta_tid(out_tid), .out_meta_tdt(out_tdt), .out_meta_sop(out_sop),
    .out_meta_eop(out_eop), .out_meta_rdy(out_rdy),
    .drop_cnt(drop_cnt), .err_cnt(err_cnt), .pkt_level(pkt_level)
  );

  function automatic word_t mk(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                               input logic [TID_W-1:0] t, input logic [TDT_W-1:0] dt,
                               input logic s, input logic e);
    return {d, k, t, dt, s, e};
  endfunction

  // Output monitor: inputs change #1 after posedge, so negedge values hold through the next edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_vld !== 1'b1 || {out_data, out_keep, out_tid, out_tdt, out_sop, out_eop}
            !== prev_word) begin
          failures++;
          $display("FAIL stall_hold vld=%b word=%h required vld=1 word=%h", out_vld,
                   {out_data, out_keep, out_tid, out_tdt, out_sop, out_eop}, prev_word);
        end
      end
      if (out_vld && out_rdy)
        cap.push_back({out_data, out_keep, out_tid, out_tdt, out_sop, out_eop});
      prev_stall = out_vld && !out_rdy;
      prev_word  = {out_data, out_keep, out_tid, out_tdt, out_sop, out_eop};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [TID_W-1:0] t,
                           input logic [TDT_W-1:0] dt, input logic s, input logic e);
    int n = 0;
    in_data = d; in_keep = 16'hFFFF; in_tid = t; in_tdt = dt;
    in_sop = s; in_eop = e; in_vld = 1'b1;
    while (!in_rdy && n < 200) begin
      tick();
      n++;
    end
    if (!in_rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_meta_rdy=%b required 1", in_rdy);
    end
    tick();
  endtask

  task automatic in_idle();
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_idle();
    repeat (3) tick();
    checks++;
    if ({in_rdy, out_vld, out_sop, out_eop} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags rdy/vld/sop/eop=%b required 0000",
               {in_rdy, out_vld, out_sop, out_eop});
    end
    checks++;
    if (drop_cnt !== 16'd0 || err_cnt !== 16'd0 || pkt_level !== 5'd0) begin
      failures++;
      $display("FAIL reset_counts drop=%0d err=%0d lvl=%0d required 0 0 0",
               drop_cnt, err_cnt, pkt_level);
    end
    rst = 1'b0;
    checks++;
    if (in_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_hold in_meta_rdy=%b required 0", in_rdy);
    end
    tick();
    checks++;
    if (in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy_rise in_meta_rdy=%b required 1", in_rdy);
    end
  endtask

  task automatic test_basic();
    cap.delete();
    exp_q.delete();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_beat(DATA_W'(i), 4'd3, 4'd1, i == 0, i == 3);
      exp_q.push_back(mk(DATA_W'(i), 16'hFFFF, 4'd3, 4'd1, i == 0, i == 3));
    end
    in_idle();
    checks++;
    if (out_vld !== 1'b0 || pkt_level !== 5'd1) begin
      failures++;
      $display("FAIL basic_commit vld=%b lvl=%0d required vld=0 lvl=1", out_vld, pkt_level);
    end
    tick();
    checks++;
    if (out_vld !== 1'b0) begin
      failures++;
      $display("FAIL basic_lat1 vld=%b required 0", out_vld);
    end
    tick();
    checks++;
    if (out_vld !== 1'b1 || out_sop !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL basic_lat2 vld=%b sop=%b data=%h required 1 1 0", out_vld, out_sop, out_data);
    end
    repeat (8) tick();
    checks++;
    if (cap.size() != 4) begin
      failures++;
      $display("FAIL basic_count got=%0d required 4", cap.size());
    end
    for (int i = 0; i < 4 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_beat%0d got=%h required %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_level !== 5'd0) begin
      failures++;
      $display("FAIL basic_level got=%0d required 0", pkt_level);
    end
  endtask

  task automatic test_back_to_back();
    cap.delete();
    exp_q.delete();
    out_rdy = 1'b1;
    fork
      begin
        for (int p = 0; p < 2; p++)
          for (int i = 0; i < 3; i++) begin
            send_beat(DATA_W'(16 * (p + 1) + i), TID_W'(p + 1), 4'd2, i == 0, i == 2);
            exp_q.push_back(mk(DATA_W'(16 * (p + 1) + i), 16'hFFFF, TID_W'(p + 1), 4'd2,
                               i == 0, i == 2));
          end
        in_idle();
      end
      begin
        repeat (30) begin
          tick();
          out_rdy = ~out_rdy;
        end
      end
    join
    out_rdy = 1'b1;
    repeat (10) tick();
    checks++;
    if (cap.size() != 6) begin
      failures++;
      $display("FAIL b2b_count got=%0d required 6", cap.size());
    end
    for (int i = 0; i < 6 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_beat%0d got=%h required %h", i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_oversize();
    logic rdy_ok = 1'b1;
    cap.delete();
    exp_q.delete();
    out_rdy = 1'b1;
    for (int i = 0; i <= DEPTH; i++) begin
      if (!in_rdy) rdy_ok = 1'b0;
      send_beat(DATA_W'(256 + i), 4'd5, 4'd0, i == 0, i == DEPTH);
    end
    for (int i = 0; i < 2; i++) begin
      if (!in_rdy) rdy_ok = 1'b0;
      send_beat(DATA_W'(512 + i), 4'd6, 4'd7, i == 0, i == 1);
      exp_q.push_back(mk(DATA_W'(512 + i), 16'hFFFF, 4'd6, 4'd7, i == 0, i == 1));
    end
    in_idle();
    repeat (10) tick();
    checks++;
    if (rdy_ok !== 1'b1) begin
      failures++;
      $display("FAIL oversize_rdy in_meta_rdy dropped low, required 1 throughout");
    end
    checks++;
    if (drop_cnt !== 16'd1) begin
      failures++;
      $display("FAIL oversize_drop got=%0d required 1", drop_cnt);
    end
    checks++;
    if (cap.size() != 2) begin
      failures++;
      $display("FAIL oversize_count got=%0d required 2", cap.size());
    end
    for (int i = 0; i < 2 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL oversize_beat%0d got=%h required %h", i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_framing();
    cap.delete();
    exp_q.delete();
    out_rdy = 1'b1;
    send_beat(DATA_W'(8'hE0), 4'd1, 4'd1, 1'b0, 1'b0);
    send_beat(DATA_W'(8'hA0), 4'd2, 4'd1, 1'b1, 1'b0);
    send_beat(DATA_W'(8'hA1), 4'd2, 4'd1, 1'b0, 1'b0);
    send_beat(DATA_W'(8'hB0), 4'd4, 4'd3, 1'b1, 1'b0);
    send_beat(DATA_W'(8'hB1), 4'd4, 4'd3, 1'b0, 1'b0);
    send_beat(DATA_W'(8'hB2), 4'd4, 4'd3, 1'b0, 1'b1);
    in_idle();
    exp_q.push_back(mk(DATA_W'(8'hB0), 16'hFFFF, 4'd4, 4'd3, 1'b1, 1'b0));
    exp_q.push_back(mk(DATA_W'(8'hB1), 16'hFFFF, 4'd4, 4'd3, 1'b0, 1'b0));
    exp_q.push_back(mk(DATA_W'(8'hB2), 16'hFFFF, 4'd4, 4'd3, 1'b0, 1'b1));
    repeat (10) tick();
    checks++;
    if (err_cnt !== 16'd2) begin
      failures++;
      $display("FAIL framing_err got=%0d required 2", err_cnt);
    end
    checks++;
    if (cap.size() != 3) begin
      failures++;
      $display("FAIL framing_count got=%0d required 3", cap.size());
    end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL framing_beat%0d got=%h required %h", i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_pkt_full();
    cap.delete();
    out_rdy = 1'b0;
    for (int i = 0; i < PKT_DEPTH; i++) send_beat(DATA_W'(i + 100), 4'd7, 4'd2, 1'b1, 1'b1);
    in_idle();
    checks++;
    if (in_rdy !== 1'b0 || pkt_level !== 5'd16) begin
      failures++;
      $display("FAIL pktfull_block rdy=%b lvl=%0d required rdy=0 lvl=16", in_rdy, pkt_level);
    end
    tick();
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    checks++;
    if (in_rdy !== 1'b1 || pkt_level !== 5'd15 || cap.size() != 1) begin
      failures++;
      $display("FAIL pktfull_release rdy=%b lvl=%0d reads=%0d required 1 15 1",
               in_rdy, pkt_level, cap.size());
    end
    out_rdy = 1'b1;
    repeat (25) tick();
    checks++;
    if (cap.size() != PKT_DEPTH) begin
      failures++;
      $display("FAIL pktfull_count got=%0d required %0d", cap.size(), PKT_DEPTH);
    end
    for (int i = 0; i < PKT_DEPTH && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== mk(DATA_W'(i + 100), 16'hFFFF, 4'd7, 4'd2, 1'b1, 1'b1)) begin
        failures++;
        $display("FAIL pktfull_beat%0d got=%h required data %0d", i, cap[i], i + 100);
      end
    end
  endtask

  task automatic test_reset_mid();
    cap.delete();
    exp_q.delete();
    out_rdy = 1'b0;
    send_beat(DATA_W'(8'h55), 4'd1, 4'd1, 1'b1, 1'b1);
    send_beat(DATA_W'(8'h60), 4'd2, 4'd1, 1'b1, 1'b0);
    send_beat(DATA_W'(8'h61), 4'd2, 4'd1, 1'b0, 1'b0);
    in_idle();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_rdy, out_vld, out_sop, out_eop} !== 4'b0000 || pkt_level !== 5'd0 ||
        drop_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_state rdy/vld/sop/eop=%b lvl=%0d drop=%0d err=%0d required 0",
               {in_rdy, out_vld, out_sop, out_eop}, pkt_level, drop_cnt, err_cnt);
    end
    out_rdy = 1'b1;
    repeat (10) tick();
    checks++;
    if (cap.size() != 0) begin
      failures++;
      $display("FAIL rstmid_flush got=%0d beats required 0", cap.size());
    end
    for (int i = 0; i < 2; i++) begin
      send_beat(DATA_W'(112 + i), 4'd9, 4'd4, i == 0, i == 1);
      exp_q.push_back(mk(DATA_W'(112 + i), 16'hFFFF, 4'd9, 4'd4, i == 0, i == 1));
    end
    in_idle();
    repeat (8) tick();
    checks++;
    if (cap.size() != 2) begin
      failures++;
      $display("FAIL rstmid_count got=%0d required 2", cap.size());
    end
    for (int i = 0; i < 2 && i < cap.size(); i++) begin
      checks++;
      if (cap[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_beat%0d got=%h required %h", i, cap[i], exp_q[i]);
      end
    end
    checks++;
    if (drop_cnt !== 16'd0 || err_cnt !== 16'd0 || pkt_level !== 5'd0) begin
      failures++;
      $display("FAIL rstmid_counts drop=%0d err=%0d lvl=%0d required 0 0 0",
               drop_cnt, err_cnt, pkt_level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_oversize();
    test_framing();
    test_pkt_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/meta_pkt_sf_fifo.md
Name: meta_pkt_sf_fifo

Overview:
- Store-and-forward packet FIFO directly downstream of the axis_test core, consuming its tx_meta stream (data/keep/tid/tdt/sop/eop).
- Buffers beats and releases a packet on its output only after the whole packet, up to eop, has been written.
- Oversize or malformed packets are dropped atomically, so downstream never sees a partial packet.
- Output uses the same meta handshake; it feeds the AXIS egress adapter.

Parameters:
- DATA_W, 128, beat data width
- KEEP_W, 16, byte-enable width (DATA_W/8)
- TID_W, 4, transaction id width
- TDT_W, 4, data-type field width
- DEPTH, 64, beat storage entries; power of 2, >=4
- PKT_DEPTH, 16, max committed packets held; power of 2, >=2

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_meta_data  in  DATA_W  beat data
- in_meta_keep  in  KEEP_W  byte enables
- in_meta_vld  in  1  input beat valid
- in_meta_tid  in  TID_W  transaction id
- in_meta_tdt  in  TDT_W  data type
- in_meta_sop  in  1  first beat of packet
- in_meta_eop  in  1  last beat of packet
- in_meta_rdy  out  1  input ready
- out_meta_data  out  DATA_W
- out_meta_keep  out  KEEP_W
- out_meta_vld  out  1
- out_meta_tid  out  TID_W
- out_meta_tdt  out  TDT_W
- out_meta_sop  out  1
- out_meta_eop  out  1
- out_meta_rdy  in  1  downstream ready
- drop_cnt  out  16  packets dropped for overflow; saturates at 0xFFFF
- err_cnt  out  16  framing errors; saturates at 0xFFFF
- pkt_level  out  log2(PKT_DEPTH)+1  committed packets not yet fully read

Behaviour:
- Reset (rst high at a clock edge):
  - all pointers, counters and state clear
  - in_meta_rdy=0, out_meta_vld=0, out_meta_sop/eop=0, drop_cnt=0, err_cnt=0, pkt_level=0
  - in_meta_rdy rises the cycle after rst deasserts
- Reset mid-packet discards all stored and partially written data; no beat is emitted afterwards.
- Handshake: a transfer occurs when vld && rdy on a clock edge.
  - out_meta_vld, once high, holds and payload stays stable until out_meta_rdy.
  - in_meta_rdy has no combinational path from in_meta_vld.
- in_meta_rdy = !rst_q && (pkt_level_committed < PKT_DEPTH). It is never lowered for beat storage full; overflow is handled by dropping.
- Write FSM states:
  - IDLE:
    - beat with sop -> write, go to PKT
    - sop&&eop -> write and commit immediately, stay IDLE
    - beat without sop -> discard, err_cnt+1
  - PKT:
    - beat written at wr_ptr; eop -> commit (commit_ptr=wr_ptr+1, packet count+1), go IDLE
    - sop seen in PKT (missing eop) -> rewind wr_ptr to commit_ptr, err_cnt+1, treat beat as first of a new packet, stay PKT
    - beat arrives while storage full -> go DROP
  - DROP: accept and discard beats; on eop, rewind wr_ptr to commit_ptr, drop_cnt+1, go IDLE. A packet longer than DEPTH always drops.
- Pointers are log2(DEPTH)+1 bits with wrap bit:
  - full when wr_ptr-rd_ptr==DEPTH
  - read side sees only data below commit_ptr
- Storage word is {data,keep,tid,tdt,sop,eop}. Memory is a synchronous-read RAM plus one output register stage.
- Latency: with output idle, the first beat of a packet asserts out_meta_vld exactly 2 cycles after the edge that accepted its eop. Thereafter one beat per cycle while out_meta_rdy=1, no bubbles within or between packets.
- pkt_level:
  - +1 on commit, -1 on output eop handshake
  - simultaneous commit and eop-read -> unchanged
- Simultaneous write and read of the same entry cannot occur, because read is limited to committed data.
- Counters saturate and never wrap.

Test Plan:
- 4-beat packet (tid=3, tdt=1, data=beat index, keep=0xFFFF), out_meta_rdy=1 -> identical 4 beats out, sop on beat 0, eop on beat 3, vld 2 cycles after eop accepted, pkt_level 1->0.
- Two back-to-back 3-beat packets, out_meta_rdy toggling 1/0 each cycle -> 6 beats out in order, payload stable while rdy=0, no duplication.
- DEPTH+1-beat packet followed by a 2-beat packet -> oversize one absent on output, drop_cnt=1, 2-beat packet intact, in_meta_rdy stays 1 throughout.
- Beat without sop while idle, then packet sop,beat,sop,beat,eop -> err_cnt=2, only the final 3-beat packet (from second sop) emitted.
- PKT_DEPTH single-beat packets with out_meta_rdy=0 -> in_meta_rdy=0 after the 16th commit; one output read -> in_meta_rdy=1 next cycle.
- rst pulsed after 2 beats of a 5-beat packet and with 1 committed packet pending -> outputs at reset values, nothing emitted; next packet passes normally with counters at 0.
